// File: rtl/cuenta_bits_envio.sv
// Bit-timing generator for the serial send path: one-cycle `tiempo` strobe at the
// end of every bit slot of a frame, followed by a silent gap of GAP_BITS periods.
module cuenta_bits_envio #(
  parameter int BIT_CYCLES = 5,
  parameter int NUM_BITS   = 11,
  parameter int GAP_BITS   = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tiempo
);

  localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BMAX = (NUM_BITS > GAP_BITS) ? NUM_BITS : GAP_BITS;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] SEND_LAST = BW'(NUM_BITS - 1);
  // GAP is unreachable when GAP_BITS==0; clamp so the constant stays in range
  localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic {SEND, GAP} state_e;

  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  state_e        state_q, state_d;
  logic          tiempo_q, tiempo_d;
  logic          eop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      state_q   <= SEND;
      tiempo_q  <= 1'b0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      state_q   <= state_d;
      tiempo_q  <= tiempo_d;
    end
  end

  always_comb begin
    eop       = (cyc_cnt_q == CYC_LAST);
    cyc_cnt_d = eop ? '0 : cyc_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    state_d   = state_q;
    tiempo_d  = eop && (state_q == SEND);
    if (eop) begin
      case (state_q)
        SEND: begin
          if (bit_cnt_q == SEND_LAST) begin
            bit_cnt_d = '0;
            if (GAP_BITS > 0) state_d = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        GAP: begin
          if (bit_cnt_q == GAP_LAST) begin
            bit_cnt_d = '0;
            state_d   = SEND;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: state_d = SEND;
      endcase
    end
  end

  assign tiempo = tiempo_q;

endmodule

// File: tb/tb_cuenta_bits_envio.sv
// Directed bench for cuenta_bits_envio: default and corner parameter sets side by
// side, hand-computed checkpoint table, closed-form strobe model and async reset.
module tb_cuenta_bits_envio;

  logic clk, rst;
  logic [3:0] t;   // 0: 5/11/2, 1: 1/3/0, 2: 1/3/1, 3: 8/11/2

  cuenta_bits_envio #(.BIT_CYCLES(5), .NUM_BITS(11), .GAP_BITS(2)) dut_a (.clk(clk), .rst(rst), .tiempo(t[0]));
  cuenta_bits_envio #(.BIT_CYCLES(1), .NUM_BITS(3),  .GAP_BITS(0)) dut_b (.clk(clk), .rst(rst), .tiempo(t[1]));
  cuenta_bits_envio #(.BIT_CYCLES(1), .NUM_BITS(3),  .GAP_BITS(1)) dut_c (.clk(clk), .rst(rst), .tiempo(t[2]));
  cuenta_bits_envio #(.BIT_CYCLES(8), .NUM_BITS(11), .GAP_BITS(2)) dut_d (.clk(clk), .rst(rst), .tiempo(t[3]));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%b expected=%b", name, k, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Strobe expected after the k-th rising edge following reset release
  function automatic logic model(input int bc, input int nb, input int gb, input int k);
    int slot;
    if (k < 1 || (k % bc) != 0) return 1'b0;
    slot = k / bc - 1;
    return ((slot % (nb + gb)) < nb);
  endfunction

  int bcs[4] = '{5, 1, 1, 8};
  int nbs[4] = '{11, 3, 3, 11};
  int gbs[4] = '{2, 0, 1, 2};
  string nm[4] = '{"a_5_11_2", "b_1_3_0", "c_1_3_1", "d_8_11_2"};

  typedef struct {
    int   sel;
    int   k;
    logic exp;
  } vec_t;

  vec_t vecs[$];
  logic hist [4][0:700];

  task automatic step_all(input string tag, input int k);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      hist[i][k] = t[i];
      chk({tag, "_", nm[i]}, k, t[i], model(bcs[i], nbs[i], gbs[i], k));
    end
  endtask

  initial begin
    int cnt;
    // default: strobes at 5,10..55; gap at 60,65; next frame 70..120; gap 125,130; 135
    vecs = '{
      '{0, 1, 1'b0}, '{0, 4, 1'b0}, '{0, 5, 1'b1}, '{0, 6, 1'b0}, '{0, 9, 1'b0},
      '{0, 10, 1'b1}, '{0, 11, 1'b0}, '{0, 55, 1'b1}, '{0, 56, 1'b0}, '{0, 60, 1'b0},
      '{0, 65, 1'b0}, '{0, 69, 1'b0}, '{0, 70, 1'b1}, '{0, 71, 1'b0}, '{0, 120, 1'b1},
      '{0, 125, 1'b0}, '{0, 130, 1'b0}, '{0, 135, 1'b1},
      '{1, 1, 1'b1}, '{1, 2, 1'b1}, '{1, 4, 1'b1}, '{1, 100, 1'b1},
      '{2, 1, 1'b1}, '{2, 3, 1'b1}, '{2, 4, 1'b0}, '{2, 5, 1'b1}, '{2, 8, 1'b0}, '{2, 9, 1'b1},
      '{3, 7, 1'b0}, '{3, 8, 1'b1}, '{3, 9, 1'b0}, '{3, 16, 1'b1}, '{3, 88, 1'b1},
      '{3, 96, 1'b0}, '{3, 104, 1'b0}, '{3, 112, 1'b1}, '{3, 113, 1'b0}, '{3, 216, 1'b1}
    };

    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_int("reset_hold_tiempo", int'(t), 0);
    end
    chk_int("reset_cyc_cnt", int'(dut_a.cyc_cnt_q), 0);
    chk_int("reset_bit_cnt", int'(dut_a.bit_cnt_q), 0);

    rst = 1'b0;
    for (int k = 1; k <= 650; k++) step_all("run", k);

    foreach (vecs[v])
      chk($sformatf("table_%0d_%s", v, nm[vecs[v].sel]), vecs[v].k,
          hist[vecs[v].sel][vecs[v].k], vecs[v].exp);

    cnt = 0;
    for (int k = 1; k <= 650; k++) cnt += int'(hist[0][k]);
    chk_int("strobes_650_default", cnt, 110);
    cnt = 0;
    for (int k = 1; k <= 650; k++) cnt += int'(hist[3][k]);
    chk_int("strobes_650_div8", cnt, 69);

    // async reset while strobe #4 is high
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k < 20; k++) @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_async_strobe4", 20, t[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_drop", 20, t[0], 1'b0);
    chk_int("async_all_low", int'(t), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 75; k++) step_all("rerun", k);
    cnt = 0;
    for (int k = 1; k < 70; k++) cnt += int'(hist[0][k]);
    chk_int("rerun_strobes_before_gap", cnt, 11);
    chk("rerun_first_strobe", 5, hist[0][5], 1'b1);
    chk("rerun_frame2_start", 70, hist[0][70], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
